// File: rtl/mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mem_arbiter
// Description : Shares one main-memory port between the instruction cache
//               (read-only) and the data cache (read/write). One requester is
//               granted at a time. The memory-side strobes, address and write
//               data are registered and held for the whole grant. The returned
//               block is registered into the owner's readdata output.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   ADDR_W        block address width (both ports and memory)
//   DATA_W        block data width (both ports and memory)
// Build option
//   ARB_DCACHE_PRIO_EN : when defined, simultaneous requests always go to
//                        the dcache. When undefined, ties are resolved
//                        round-robin; the first tie after reset goes to the
//                        icache.
// Ports
//   CLK           in   system clock, rising edge
//   RESET         in   asynchronous active-low reset
//   i_read        in   icache read request, held until i_busywait=0
//   i_address     in   icache block address
//   i_readdata    out  block returned to icache (registered)
//   i_busywait    out  icache stall
//   d_read        in   dcache read request
//   d_write       in   dcache write request (writeback)
//   d_address     in   dcache block address
//   d_writedata   in   dcache writeback block
//   d_readdata    out  block returned to dcache (registered)
//   d_busywait    out  dcache stall
//   mem_read      out  memory read strobe
//   mem_write     out  memory write strobe
//   mem_address   out  memory block address
//   mem_writedata out  memory write block
//   mem_readdata  in   memory read block
//   mem_busywait  in   memory busy; falls when the access completes
//============================================================================
module mem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   // icache port
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_busywait,
   // dcache port
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_busywait,
   // memory port
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_busywait
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_I = 2'd1,
      S_GRANT_D = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Owner encoding shared by the owner and last registers
   localparam logic c_own_i = 1'b0;
   localparam logic c_own_d = 1'b1;

   state_t              state_q,     state_d;
   logic                owner_q,     owner_d;
   logic                last_q,      last_d;
   logic                first_q,     first_d;
   logic                mem_read_q,  mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

   logic w_req_i;
   logic w_req_d;
   logic w_pick_d;

   assign w_req_i = i_read;
   assign w_req_d = d_read | d_write;

   // Arbitration: decides whether the dcache wins a grant taken in IDLE.
`ifdef ARB_DCACHE_PRIO_EN
   assign w_pick_d = w_req_d;
`else
   // On a tie, the port that did not complete the previous access wins.
   assign w_pick_d = w_req_d & (~w_req_i | (last_q == c_own_i));
`endif

   //------------------------------------------------------------------------
   // Next-state and registered-output logic
   //------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      first_d     = first_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (w_req_i || w_req_d) begin
               first_d = 1'b1;
               if (w_pick_d) begin
                  state_d     = S_GRANT_D;
                  owner_d     = c_own_d;
                  mem_addr_d  = d_address;
                  mem_wdata_d = d_writedata;
                  // A simultaneous read and write is served as a write.
                  mem_write_d = d_write;
                  mem_read_d  = ~d_write;
               end else begin
                  state_d     = S_GRANT_I;
                  owner_d     = c_own_i;
                  mem_addr_d  = i_address;
                  mem_wdata_d = '0;
                  mem_write_d = 1'b0;
                  mem_read_d  = 1'b1;
               end
            end
         end

         S_GRANT_I, S_GRANT_D: begin
            // The first grant cycle is ignored: memory has not yet had a
            // full cycle to raise its busywait in response to the strobe.
            if (first_q) begin
               first_d = 1'b0;
            end else if (!mem_busywait) begin
               if (mem_read_q) begin
                  if (owner_q == c_own_d) begin
                     d_rdata_d = mem_readdata;
                  end else begin
                     i_rdata_d = mem_readdata;
                  end
               end
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               last_d      = owner_q;
               state_d     = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   //------------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         owner_q     <= c_own_i;
         last_q      <= c_own_d;
         first_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         first_q     <= first_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   //------------------------------------------------------------------------
   // Outputs
   //------------------------------------------------------------------------
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_addr_q;
   assign mem_writedata = mem_wdata_q;
   assign i_readdata    = i_rdata_q;
   assign d_readdata    = d_rdata_q;

   // A port stalls while it requests, except in its own DONE cycle.
   assign i_busywait = w_req_i & ~((state_q == S_DONE) & (owner_q == c_own_i));
   assign d_busywait = w_req_d & ~((state_q == S_DONE) & (owner_q == c_own_d));

endmodule
`default_nettype wire
